// File: rtl/core_eot_pkg.sv
// Shared types and constants for the end-of-test monitor (core_eot_monitor).
package core_eot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } eot_state_e;

  localparam logic [31:0] DEF_TOHOST_ADDR  = 32'h8000_1000;
  localparam logic [31:0] DEF_CONSOLE_ADDR = 32'h8000_1004;
  localparam logic [31:0] EOT_PASS_VAL     = 32'd1;
  localparam logic [3:0]  BE_WORD          = 4'hF;
  localparam logic [3:0]  BE_BYTE0         = 4'h1;

  // True when the data port carries a store to the given byte address.
  function automatic logic is_store_to(input logic        valid,
                                       input logic        we,
                                       input logic [31:0] addr,
                                       input logic [31:0] target);
    is_store_to = valid & we & (addr == target);
  endfunction

endpackage

// File: rtl/core_eot_console_fifo.sv
// Small synchronous byte FIFO for console characters; overflow_r is a sticky
// drop indicator meant to be read hierarchically.
module core_eot_console_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr_r;
  logic [AW:0]   rd_ptr_r;
  logic [W-1:0]  mem_r [DEPTH];
  logic          overflow_r;
  logic          full_s;
  logic          empty_s;
  logic          do_push_s;
  logic          do_pop_s;

  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);

  // A push into a full FIFO is still accepted if the head leaves the same cycle.
  assign do_pop_s  = pop & ~empty_s;
  assign do_push_s = push & (~full_s | do_pop_s);

  assign out_valid = ~empty_s;
  assign out_data  = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer and overflow flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (push && !do_push_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/core_eot_monitor.sv
// End-of-test monitor: decodes tohost stores, counts cycles/retires, flags
// pass/fail/timeout. Optional console FIFO enabled by macro EOT_CONSOLE_EN.
module core_eot_monitor
  import core_eot_pkg::*;
#(
  parameter logic [31:0] TOHOST_ADDR    = DEF_TOHOST_ADDR,
  parameter logic [31:0] CONSOLE_ADDR   = DEF_CONSOLE_ADDR,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned CON_DEPTH      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             test_start,
  input  logic             dmem_valid,
  input  logic             dmem_we,
  input  logic [31:0]      dmem_addr,
  input  logic [3:0]       dmem_be,
  input  logic [31:0]      dmem_wdata,
  input  logic             retire_valid,
  output logic             eot_done,
  output logic             eot_pass,
  output logic             eot_timeout,
  output logic [30:0]      eot_code,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt,
  output logic             con_valid,
  output logic [7:0]       con_data,
  input  logic             con_ready
);

  localparam logic             TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  eot_state_e       state_r, state_s;
  logic             done_r, done_s;
  logic             pass_r, pass_s;
  logic             timeout_r, timeout_s;
  logic [30:0]      code_r, code_s;
  logic [CNT_W-1:0] cyc_r, cyc_s;
  logic [CNT_W-1:0] ins_r, ins_s;
  logic             in_run_s;
  logic             hit_s;
  logic             limit_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign in_run_s = (state_r == ST_RUN);
  // Even-valued tohost writes are syscall slots and never end the test.
  assign hit_s    = in_run_s && is_store_to(dmem_valid, dmem_we, dmem_addr, TOHOST_ADDR)
                    && (dmem_be == BE_WORD) && dmem_wdata[0];
  assign limit_s  = TO_EN && (cyc_r == TO_LIMIT);

  // Next-state, status and counter update logic.
  always_comb begin
    state_s   = state_r;
    done_s    = done_r;
    pass_s    = pass_r;
    timeout_s = timeout_r;
    code_s    = code_r;
    cyc_s     = cyc_r;
    ins_s     = ins_r;
    if (test_start) begin
      state_s   = ST_RUN;
      done_s    = 1'b0;
      pass_s    = 1'b0;
      timeout_s = 1'b0;
      code_s    = 31'd0;
      cyc_s     = '0;
      ins_s     = '0;
    end else begin
      case (state_r)
        ST_RUN: begin
          cyc_s = sat_inc(cyc_r);
          if (retire_valid) begin
            ins_s = sat_inc(ins_r);
          end else begin
            ins_s = ins_r;
          end
          if (hit_s) begin
            done_s = 1'b1;
            if (dmem_wdata == EOT_PASS_VAL) begin
              state_s = ST_PASS;
              pass_s  = 1'b1;
              code_s  = 31'd0;
            end else begin
              state_s = ST_FAIL;
              pass_s  = 1'b0;
              code_s  = dmem_wdata[31:1];
            end
          end else if (limit_s) begin
            state_s   = ST_TIMEOUT;
            done_s    = 1'b1;
            timeout_s = 1'b1;
          end else begin
            state_s = ST_RUN;
          end
        end
        ST_IDLE, ST_PASS, ST_FAIL, ST_TIMEOUT: begin
          state_s = state_r;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, status and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      done_r    <= 1'b0;
      pass_r    <= 1'b0;
      timeout_r <= 1'b0;
      code_r    <= 31'd0;
      cyc_r     <= '0;
      ins_r     <= '0;
    end else begin
      state_r   <= state_s;
      done_r    <= done_s;
      pass_r    <= pass_s;
      timeout_r <= timeout_s;
      code_r    <= code_s;
      cyc_r     <= cyc_s;
      ins_r     <= ins_s;
    end
  end

  assign eot_done    = done_r;
  assign eot_pass    = pass_r;
  assign eot_timeout = timeout_r;
  assign eot_code    = code_r;
  assign cycle_cnt   = cyc_r;
  assign instret_cnt = ins_r;

`ifdef EOT_CONSOLE_EN
  logic con_push_s;

  assign con_push_s = in_run_s
                      && is_store_to(dmem_valid, dmem_we, dmem_addr, CONSOLE_ADDR)
                      && ((dmem_be == BE_WORD) || (dmem_be == BE_BYTE0));

  core_eot_console_fifo #(
    .DEPTH (CON_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (con_push_s),
    .push_data (dmem_wdata[7:0]),
    .pop       (con_ready),
    .out_valid (con_valid),
    .out_data  (con_data)
  );
`else
  logic unused_con_s;

  assign unused_con_s = con_ready;
  assign con_valid    = 1'b0;
  assign con_data     = 8'h00;
`endif

endmodule

// File: tb/tb_core_eot_monitor.sv
// Scoreboard bench for core_eot_monitor: one default instance and one with a
// 20-cycle timeout share the same stimulus.
module tb_core_eot_monitor;
  import core_eot_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        test_start = 1'b0;
  logic        dmem_valid = 1'b0;
  logic        dmem_we = 1'b0;
  logic [31:0] dmem_addr = 32'd0;
  logic [3:0]  dmem_be = 4'd0;
  logic [31:0] dmem_wdata = 32'd0;
  logic        retire_valid = 1'b0;
  logic        con_ready = 1'b0;

  logic        d0_done, d0_pass, d0_tmo, d0_cv;
  logic [30:0] d0_code;
  logic [31:0] d0_cyc, d0_ins;
  logic [7:0]  d0_cd;
  logic        d1_done, d1_pass, d1_tmo, d1_cv;
  logic [30:0] d1_code;
  logic [31:0] d1_cyc, d1_ins;
  logic [7:0]  d1_cd;

  int n_total = 0;
  int n_bad   = 0;

  localparam logic [31:0] TH = 32'h8000_1000;
  localparam logic [31:0] CA = 32'h8000_1004;

  always #5 clk = ~clk;

  core_eot_monitor u0 (
    .clk(clk), .rst_n(rst_n), .test_start(test_start), .dmem_valid(dmem_valid),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .retire_valid(retire_valid), .eot_done(d0_done), .eot_pass(d0_pass),
    .eot_timeout(d0_tmo), .eot_code(d0_code), .cycle_cnt(d0_cyc), .instret_cnt(d0_ins),
    .con_valid(d0_cv), .con_data(d0_cd), .con_ready(con_ready)
  );

  core_eot_monitor #(.TIMEOUT_CYCLES(20)) u_to (
    .clk(clk), .rst_n(rst_n), .test_start(test_start), .dmem_valid(dmem_valid),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .retire_valid(retire_valid), .eot_done(d1_done), .eot_pass(d1_pass),
    .eot_timeout(d1_tmo), .eot_code(d1_code), .cycle_cnt(d1_cyc), .instret_cnt(d1_ins),
    .con_valid(d1_cv), .con_data(d1_cd), .con_ready(con_ready)
  );

  typedef struct {
    string       tag;
    bit          sel;
    logic        done;
    logic        pass;
    logic        tmo;
    logic [30:0] code;
    logic [31:0] cyc;
    logic [31:0] ins;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input bit sel, input logic done, input logic pass,
                         input logic tmo, input logic [30:0] code, input logic [31:0] cyc,
                         input logic [31:0] ins);
    exp_t e;
    e.tag = tag; e.sel = sel; e.done = done; e.pass = pass; e.tmo = tmo;
    e.code = code; e.cyc = cyc; e.ins = ins;
    sbq.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    if (sbq.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      if (e.sel) begin
        chk({e.tag, ".done"}, {31'd0, d1_done}, {31'd0, e.done});
        chk({e.tag, ".pass"}, {31'd0, d1_pass}, {31'd0, e.pass});
        chk({e.tag, ".tmo"},  {31'd0, d1_tmo},  {31'd0, e.tmo});
        chk({e.tag, ".code"}, {1'b0, d1_code},  {1'b0, e.code});
        chk({e.tag, ".cyc"},  d1_cyc, e.cyc);
        chk({e.tag, ".ins"},  d1_ins, e.ins);
      end else begin
        chk({e.tag, ".done"}, {31'd0, d0_done}, {31'd0, e.done});
        chk({e.tag, ".pass"}, {31'd0, d0_pass}, {31'd0, e.pass});
        chk({e.tag, ".tmo"},  {31'd0, d0_tmo},  {31'd0, e.tmo});
        chk({e.tag, ".code"}, {1'b0, d0_code},  {1'b0, e.code});
        chk({e.tag, ".cyc"},  d0_cyc, e.cyc);
        chk({e.tag, ".ins"},  d0_ins, e.ins);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    test_start = 1'b1;
    tick(1);
    test_start = 1'b0;
  endtask

  task automatic store(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data);
    dmem_valid = 1'b1; dmem_we = 1'b1; dmem_addr = addr; dmem_be = be; dmem_wdata = data;
    tick(1);
    dmem_valid = 1'b0; dmem_we = 1'b0; dmem_addr = 32'd0; dmem_be = 4'd0; dmem_wdata = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    sb_push("reset0", 1'b0, 1'b0, 1'b0, 1'b0, 31'd0, 32'd0, 32'd0); sb_check();
    sb_push("reset1", 1'b1, 1'b0, 1'b0, 1'b0, 31'd0, 32'd0, 32'd0); sb_check();
    chk("reset.cv", {31'd0, d0_cv}, 32'd0);
    rst_n = 1'b1;
    tick(2);
    sb_push("idle_hold", 1'b0, 1'b0, 1'b0, 1'b0, 31'd0, 32'd0, 32'd0); sb_check();

    // pass after 50 retiring cycles
    pulse_start();
    retire_valid = 1'b1;
    tick(50);
    retire_valid = 1'b0;
    store(TH, 4'hF, 32'h1);
    sb_push("pass", 1'b0, 1'b1, 1'b1, 1'b0, 31'd0, 32'd51, 32'd50); sb_check();
    tick(4);
    sb_push("pass_frozen", 1'b0, 1'b1, 1'b1, 1'b0, 31'd0, 32'd51, 32'd50); sb_check();

    // fail codes
    pulse_start();
    tick(5);
    store(TH, 4'hF, 32'h0000_0007);
    sb_push("fail7", 1'b0, 1'b1, 1'b0, 1'b0, 31'd3, 32'd6, 32'd0); sb_check();
    pulse_start();
    store(TH, 4'hF, 32'hFFFF_FFFF);
    sb_push("fail_ones", 1'b0, 1'b1, 1'b0, 1'b0, 31'h7FFF_FFFF, 32'd1, 32'd0); sb_check();

    // ignored tohost writes, retires, restart mid-run
    pulse_start();
    store(TH, 4'hF, 32'h2);
    store(TH, 4'h1, 32'h1);
    sb_push("ignored", 1'b0, 1'b0, 1'b0, 1'b0, 31'd0, 32'd2, 32'd0); sb_check();
    retire_valid = 1'b1;
    tick(10);
    retire_valid = 1'b0;
    sb_push("retire10", 1'b0, 1'b0, 1'b0, 1'b0, 31'd0, 32'd12, 32'd10); sb_check();
    pulse_start();
    sb_push("restart", 1'b0, 1'b0, 1'b0, 1'b0, 31'd0, 32'd0, 32'd0); sb_check();
    tick(1);
    sb_push("resume", 1'b0, 1'b0, 1'b0, 1'b0, 31'd0, 32'd1, 32'd0); sb_check();

    // timeout boundary on the 20-cycle instance
    pulse_start();
    tick(19);
    sb_push("to_pre", 1'b1, 1'b0, 1'b0, 1'b0, 31'd0, 32'd19, 32'd0); sb_check();
    tick(1);
    sb_push("to_fire", 1'b1, 1'b1, 1'b0, 1'b1, 31'd0, 32'd20, 32'd0); sb_check();
    tick(3);
    sb_push("to_hold", 1'b1, 1'b1, 1'b0, 1'b1, 31'd0, 32'd20, 32'd0); sb_check();
    pulse_start();
    tick(19);
    store(TH, 4'hF, 32'h1);
    sb_push("to_hitwins", 1'b1, 1'b1, 1'b1, 1'b0, 31'd0, 32'd20, 32'd0); sb_check();

    // async reset mid-run
    pulse_start();
    tick(5);
    rst_n = 1'b0;
    #1;
    sb_push("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 31'd0, 32'd0, 32'd0); sb_check();
    tick(1);
    rst_n = 1'b1;
    tick(2);
    sb_push("post_rst_idle", 1'b0, 1'b0, 1'b0, 1'b0, 31'd0, 32'd0, 32'd0); sb_check();

    // console path
    pulse_start();
`ifdef EOT_CONSOLE_EN
    store(CA, 4'hF, 32'h0000_0048);
    store(CA, 4'h1, 32'h0000_0069);
    chk("con_v0", {31'd0, d0_cv}, 32'd1);
    chk("con_H", {24'd0, d0_cd}, 32'h48);
    con_ready = 1'b1;
    tick(1);
    chk("con_i", {24'd0, d0_cd}, 32'h69);
    tick(1);
    con_ready = 1'b0;
    chk("con_empty", {31'd0, d0_cv}, 32'd0);
    for (int i = 0; i < 16; i++) store(CA, 4'hF, 32'(8'h30 + i));
    chk("con_no_ovf", {31'd0, u0.u_fifo.overflow_r}, 32'd0);
    store(CA, 4'hF, 32'h0000_00EE);
    chk("con_ovf", {31'd0, u0.u_fifo.overflow_r}, 32'd1);
    chk("con_head", {24'd0, d0_cd}, 32'h30);
`else
    store(CA, 4'hF, 32'h0000_0048);
    chk("con_off_v", {31'd0, d0_cv}, 32'd0);
    chk("con_off_d", {24'd0, d0_cd}, 32'd0);
`endif
    sb_push("con_run", 1'b0, 1'b0, 1'b0, 1'b0, 31'd0, d0_cyc, 32'd0);
    chk("con_cyc_nonzero", {31'd0, (d0_cyc != 32'd0)}, 32'd1);
    sb_check();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
